// File: rtl/quad_decoder.sv
// Quadrature encoder front end: two-flop synchroniser, stability filter and
// x4 decoder driving a wrapping position counter with step/dir/err flags.
module quad_decoder #(
   parameter int WIDTH  = 16,
   parameter int FILTER = 4
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             clear,
   input  logic             err_clear,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             step,
   output logic             err
);
   localparam logic [7:0]       FILT_LAST = 8'(FILTER - 1);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   logic [1:0]       sync1_reg;
   logic [1:0]       s_reg;
   logic [1:0]       s_last_reg;
   logic [1:0]       f_reg;
   logic [1:0]       p_reg;
   logic [7:0]       filt_cnt_reg;
   logic [7:0]       filt_base;
   logic [WIDTH-1:0] count_reg;
   logic             dir_reg;
   logic             step_reg;
   logic             err_reg;
   logic             dec_en;
   logic             is_fwd;
   logic             is_rev;
   logic             is_bad;

   // A new synchronised value that differs from the one being qualified
   // starts its stability count from scratch.
   assign filt_base = (s_reg != s_last_reg) ? 8'd0 : filt_cnt_reg;

   // Forward successor of {a,b} in the Gray cycle 00->10->11->01 is {~b,a}.
   assign dec_en = (f_reg != p_reg);
   assign is_fwd = dec_en && (f_reg == {~p_reg[0], p_reg[1]});
   assign is_rev = dec_en && (p_reg == {~f_reg[0], f_reg[1]});
   assign is_bad = dec_en && !is_fwd && !is_rev;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sync1_reg    <= 2'b00;
         s_reg        <= 2'b00;
         s_last_reg   <= 2'b00;
         f_reg        <= 2'b00;
         p_reg        <= 2'b00;
         filt_cnt_reg <= 8'd0;
         count_reg    <= '0;
         dir_reg      <= 1'b0;
         step_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         sync1_reg  <= {enc_a, enc_b};
         s_reg      <= sync1_reg;
         s_last_reg <= s_reg;

         if (s_reg == f_reg) begin
            filt_cnt_reg <= 8'd0;
         end else if (filt_base == FILT_LAST) begin
            f_reg        <= s_reg;
            filt_cnt_reg <= 8'd0;
         end else begin
            filt_cnt_reg <= filt_base + 8'd1;
         end

         p_reg    <= f_reg;
         step_reg <= is_fwd || is_rev;

         if (clear) begin
            count_reg <= '0;
         end else if (is_fwd) begin
            count_reg <= count_reg + ONE;
         end else if (is_rev) begin
            count_reg <= count_reg - ONE;
         end

         if (is_fwd) begin
            dir_reg <= 1'b1;
         end else if (is_rev) begin
            dir_reg <= 1'b0;
         end

         // An illegal decode on the same edge outranks err_clear.
         if (is_bad) begin
            err_reg <= 1'b1;
         end else if (err_clear) begin
            err_reg <= 1'b0;
         end
      end
   end

   assign count = count_reg;
   assign dir   = dir_reg;
   assign step  = step_reg;
   assign err   = err_reg;
endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus random encoder traffic,
// checked by a run-length/Gray-position reference model and step scoreboard.
module tb_quad_decoder;
   localparam int WIDTH  = 16;
   localparam int FILTER = 4;

   logic             clk = 1'b0;
   logic             rstb = 1'b0;
   logic             enc_a = 1'b0;
   logic             enc_b = 1'b0;
   logic             clear = 1'b0;
   logic             err_clear = 1'b0;
   logic [WIDTH-1:0] count;
   logic             dir;
   logic             step;
   logic             err;

   quad_decoder #(.WIDTH(WIDTH), .FILTER(FILTER)) dut (
      .clk(clk), .rstb(rstb), .enc_a(enc_a), .enc_b(enc_b),
      .clear(clear), .err_clear(err_clear),
      .count(count), .dir(dir), .step(step), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int steps_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Position of a pin pair along the forward Gray cycle 00,10,11,01.
   function automatic int gpos(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   typedef struct { int at; logic [1:0] val; } pend_t;
   typedef struct { logic [WIDTH-1:0] cnt; logic d; } exp_t;

   pend_t pend_q[$];
   exp_t  exp_q[$];

   logic [WIDTH-1:0] m_count;
   logic             m_dir, m_err;
   logic [1:0]       m_f, m_p, run_val;
   int               run_len, cyc;

   // Reference model: a pin value is accepted once seen on FILTER consecutive
   // edges; its decode lands three edges later.
   always @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         m_count = '0; m_dir = 1'b0; m_err = 1'b0;
         m_f = 2'b00; m_p = 2'b00; run_val = 2'b00; run_len = FILTER; cyc = 0;
         pend_q.delete();
         exp_q.delete();
      end else begin
         int   delta;
         logic stepped;
         logic [1:0] v;
         cyc++;
         delta = 0;
         stepped = 1'b0;
         if (pend_q.size() != 0 && pend_q[0].at == cyc) begin
            int d;
            d = (gpos(pend_q[0].val) - gpos(m_p) + 4) % 4;
            m_p = pend_q[0].val;
            void'(pend_q.pop_front());
            if (d == 1) begin delta = 1; m_dir = 1'b1; stepped = 1'b1; end
            else if (d == 3) begin delta = -1; m_dir = 1'b0; stepped = 1'b1; end
            else m_err = 1'b1;
            if (d == 2) ; else if (err_clear) m_err = 1'b0;
         end else if (err_clear) begin
            m_err = 1'b0;
         end
         m_count = clear ? '0 : m_count + WIDTH'(delta);
         if (stepped) exp_q.push_back('{cnt: m_count, d: m_dir});
         v = {enc_a, enc_b};
         if (v == run_val) run_len++;
         else begin run_val = v; run_len = 1; end
         if (run_val != m_f && run_len >= FILTER) begin
            m_f = run_val;
            pend_q.push_back('{at: cyc + 3, val: run_val});
         end
      end
   end

   logic prev_step = 1'b0;

   always @(negedge clk) begin
      if (rstb) begin
         chk("step_expected", {31'd0, step}, {31'd0, exp_q.size() != 0});
         chk("step_gap", {31'd0, step && prev_step}, 32'd0);
         if (step) steps_seen++;
         if (step && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("step_count", 32'(count), 32'(e.cnt));
            chk("step_dir", {31'd0, dir}, {31'd0, e.d});
         end else begin
            exp_q.delete();
         end
         chk("count_track", 32'(count), 32'(m_count));
         chk("dir_track", {31'd0, dir}, {31'd0, m_dir});
         chk("err_track", {31'd0, err}, {31'd0, m_err});
      end
      prev_step = rstb ? step : 1'b0;
   end

   task automatic drive(input logic [1:0] v, input int hold);
      @(negedge clk);
      {enc_a, enc_b} = v;
      repeat (hold - 1) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, s0;
      logic found;
      logic [1:0] gseq [4];
      gseq[0] = 2'b00; gseq[1] = 2'b10; gseq[2] = 2'b11; gseq[3] = 2'b01;

      repeat (3) @(negedge clk);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_dir", {31'd0, dir}, 32'd0);
      chk("reset_step", {31'd0, step}, 32'd0);
      chk("reset_err", {31'd0, err}, 32'd0);
      rstb = 1'b1;
      repeat (5) @(negedge clk);

      // Forward rotation with latency measurement on the first edge.
      enc_a = 1'b1;
      n = 0; found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk); #1;
         n++;
         if (step) found = 1'b1;
      end
      chk("fwd_latency", 32'(n - 1), 32'(FILTER + 2));
      repeat (5) @(negedge clk);
      drive(2'b11, 10); drive(2'b01, 10); drive(2'b00, 10);
      repeat (8) @(negedge clk);
      chk("fwd_count", 32'(count), 32'd4);
      chk("fwd_dir", {31'd0, dir}, 32'd1);

      drive(2'b01, 10); drive(2'b11, 10); drive(2'b10, 10);
      drive(2'b00, 10); drive(2'b01, 10); drive(2'b11, 10);
      repeat (8) @(negedge clk);
      chk("rev_count", 32'(count), 32'hFFFE);
      chk("rev_dir", {31'd0, dir}, 32'd0);
      chk("rev_err", {31'd0, err}, 32'd0);
      drive(2'b10, 10); drive(2'b00, 10);
      repeat (8) @(negedge clk);

      s0 = steps_seen;
      for (int i = 0; i < 5; i++) begin
         drive(2'b10, 3); drive(2'b00, 10);
      end
      chk("glitch_steps", 32'(steps_seen - s0), 32'd0);
      chk("glitch_count", 32'(count), 32'hFFFC);
      s0 = steps_seen;
      drive(2'b10, 4); drive(2'b00, 12);
      chk("accept4_steps", 32'(steps_seen - s0), 32'd2);

      s0 = steps_seen;
      drive(2'b11, 12);
      chk("illegal_err", {31'd0, err}, 32'd1);
      chk("illegal_count", 32'(count), 32'hFFFC);
      chk("illegal_steps", 32'(steps_seen - s0), 32'd0);
      @(negedge clk) err_clear = 1'b1;
      @(negedge clk) err_clear = 1'b0;
      chk("err_cleared", {31'd0, err}, 32'd0);
      drive(2'b00, 12);
      @(negedge clk) err_clear = 1'b1;
      @(negedge clk) err_clear = 1'b0;
      @(negedge clk) clear = 1'b1;
      @(negedge clk) clear = 1'b0;
      chk("clear_count", 32'(count), 32'd0);

      drive(2'b01, 10);
      chk("wrap_down", 32'(count), 32'hFFFF);
      drive(2'b00, 10);
      chk("wrap_up", 32'(count), 32'd0);
      drive(2'b10, 10);
      @(negedge clk) {enc_a, enc_b} = 2'b11;
      repeat (6) @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      chk("clr_prio_step", {31'd0, step}, 32'd1);
      chk("clr_prio_count", 32'(count), 32'd0);
      chk("clr_prio_dir", {31'd0, dir}, 32'd1);
      @(negedge clk) clear = 1'b0;
      repeat (5) @(negedge clk);

      drive(2'b01, 10);
      chk("pre_rst_count", 32'(count), 32'd1);
      @(negedge clk) {enc_a, enc_b} = 2'b00;
      @(posedge clk); @(posedge clk); #2;
      rstb = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_dir", {31'd0, dir}, 32'd0);
      chk("arst_step", {31'd0, step}, 32'd0);
      chk("arst_err", {31'd0, err}, 32'd0);
      @(posedge clk); #3;
      rstb = 1'b1;
      s0 = steps_seen;
      repeat (20) @(negedge clk);
      chk("post_rst_steps", 32'(steps_seen - s0), 32'd0);
      chk("post_rst_err", {31'd0, err}, 32'd0);

      // Random traffic: mostly legal Gray moves, some jumps and glitches.
      for (int c = 0; c < 3000; c++) begin
         int r;
         @(negedge clk);
         r = $urandom_range(0, 9);
         if (r == 6 || r == 7) {enc_a, enc_b} = gseq[(gpos({enc_a, enc_b}) + 1) % 4];
         else if (r == 8) {enc_a, enc_b} = gseq[(gpos({enc_a, enc_b}) + 3) % 4];
         else if (r == 9) {enc_a, enc_b} = 2'($urandom_range(0, 3));
         clear = ($urandom_range(0, 40) == 0);
         err_clear = ($urandom_range(0, 20) == 0);
      end
      @(negedge clk);
      clear = 1'b0; err_clear = 1'b0;
      repeat (20) @(negedge clk);
      chk("rand_drain", 32'(exp_q.size() + pend_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
